// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO.
package sync_fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int fifo_depth(input int asize);
        return 1 << asize;
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Write/read flag interface of the single-clock FIFO; master drives requests, slave is the FIFO.
interface sync_fifo_if #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
);
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             wfull;
    logic             awfull;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             arempty;
    logic [ASIZE:0]   afull_th;
    logic [ASIZE:0]   aempty_th;
    logic [ASIZE:0]   level;
    logic             overflow;
    logic             underflow;
    logic             clr_err;

    modport master (
        output winc, wdata, rinc, afull_th, aempty_th, clr_err,
        input  wfull, awfull, rdata, rempty, arempty, level, overflow, underflow
    );

    modport slave (
        input  winc, wdata, rinc, afull_th, aempty_th, clr_err,
        output wfull, awfull, rdata, rempty, arempty, level, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ram.sv
// Flop-array storage with a gated write port and an asynchronous read port; contents are not reset.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);
    logic [DSIZE-1:0] mem [fifo_depth(ASIZE)];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, exact fill level, programmable almost flags, sticky errors,
// and either a registered read port or first-word-fall-through output.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4,
    parameter int FWFT  = FIFO_STD
) (
    input logic        clk,
    input logic        rst,
    sync_fifo_if.slave bus
);
    localparam logic [ASIZE:0] DEPTH = (ASIZE+1)'(fifo_depth(ASIZE));

    logic [ASIZE:0]   wptr;
    logic [ASIZE:0]   rptr;
    logic [ASIZE:0]   level;
    logic             full;
    logic             empty;
    logic             wr_en;
    logic             rd_en;
    logic             overflow_q;
    logic             underflow_q;
    logic [DSIZE-1:0] head;

    assign full  = (level == DEPTH);
    assign empty = (level == '0);
    assign wr_en = bus.winc && !full;
    assign rd_en = bus.rinc && !empty;

    // Threshold edge cases fall out of the compares: th=0 always meets >=, th>=DEPTH always meets <=.
    assign bus.wfull     = full;
    assign bus.rempty    = empty;
    assign bus.awfull    = (level >= bus.afull_th);
    assign bus.arempty   = (level <= bus.aempty_th);
    assign bus.level     = level;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
            if (wr_en && !rd_en)
                level <= level + 1'b1;
            else if (rd_en && !wr_en)
                level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.winc && full)
                overflow_q <= 1'b1;
            else if (bus.clr_err)
                overflow_q <= 1'b0;
            if (bus.rinc && empty)
                underflow_q <= 1'b1;
            else if (bus.clr_err)
                underflow_q <= 1'b0;
        end
    end

    sync_fifo_ram #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wptr[ASIZE-1:0]),
        .wdata (bus.wdata),
        .raddr (rptr[ASIZE-1:0]),
        .rdata (head)
    );

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            // Masked while empty so the port reads zero after reset rather than stale storage.
            assign bus.rdata = empty ? '0 : head;
        end else begin : g_std
            logic [DSIZE-1:0] rdata_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    rdata_q <= '0;
                else if (rd_en)
                    rdata_q <= head;
            end
            assign bus.rdata = rdata_q;
        end
    endgenerate
endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: a standard-mode and an FWFT-mode instance share clock and reset.
module tb_sync_fifo;
    import sync_fifo_pkg::*;

    localparam int DSIZE = 8;
    localparam int ASIZE = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [7:0] sb[$];
    logic [7:0] exp_rdata;
    logic       ovf_m;
    logic       unf_m;

    sync_fifo_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) if_s ();
    sync_fifo_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) if_f ();

    sync_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE), .FWFT(FIFO_STD)) dut_std (
        .clk (clk),
        .rst (rst),
        .bus (if_s)
    );

    sync_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE), .FWFT(FIFO_FWFT)) dut_fwft (
        .clk (clk),
        .rst (rst),
        .bus (if_f)
    );

    always #5 clk = ~clk;

    // One clock of the standard-mode DUT with the scoreboard advanced alongside it.
    task automatic step_std(input logic w, input logic [7:0] d, input logic r, input logic clr,
                            output logic rd_ok, output logic [7:0] rd_exp);
        logic wa;
        wa     = w && (sb.size() < DEPTH);
        rd_ok  = r && (sb.size() > 0);
        rd_exp = '0;
        if (w && sb.size() == DEPTH) ovf_m = 1'b1;
        else if (clr) ovf_m = 1'b0;
        if (r && sb.size() == 0) unf_m = 1'b1;
        else if (clr) unf_m = 1'b0;
        if_s.winc = w; if_s.wdata = d; if_s.rinc = r; if_s.clr_err = clr;
        @(posedge clk); #1;
        if (rd_ok) begin
            rd_exp    = sb.pop_front();
            exp_rdata = rd_exp;
        end
        if (wa) sb.push_back(d);
        if_s.winc = 1'b0; if_s.rinc = 1'b0; if_s.clr_err = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks += 8;
        if (if_s.level !== 5'd0)   begin failures++; $display("FAIL reset_level: got %0d expected 0", if_s.level); end
        if (if_s.rempty !== 1'b1)  begin failures++; $display("FAIL reset_rempty: got %b expected 1", if_s.rempty); end
        if (if_s.arempty !== 1'b1) begin failures++; $display("FAIL reset_arempty: got %b expected 1", if_s.arempty); end
        if (if_s.wfull !== 1'b0)   begin failures++; $display("FAIL reset_wfull: got %b expected 0", if_s.wfull); end
        if (if_s.awfull !== 1'b0)  begin failures++; $display("FAIL reset_awfull: got %b expected 0", if_s.awfull); end
        if (if_s.rdata !== 8'h00)  begin failures++; $display("FAIL reset_rdata: got %h expected 00", if_s.rdata); end
        if (if_s.overflow !== 1'b0 || if_s.underflow !== 1'b0) begin
            failures++; $display("FAIL reset_errs: got %b%b expected 00", if_s.overflow, if_s.underflow);
        end
        if (if_f.rempty !== 1'b1)  begin failures++; $display("FAIL reset_fwft_rempty: got %b expected 1", if_f.rempty); end
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete(); exp_rdata = '0; ovf_m = 1'b0; unf_m = 1'b0;
    endtask

    task automatic test_fill_drain();
        logic ok; logic [7:0] e;
        for (int i = 0; i < DEPTH; i++) begin
            step_std(1'b1, 8'(i), 1'b0, 1'b0, ok, e);
            checks += 3;
            if (if_s.level !== 5'(i + 1)) begin failures++; $display("FAIL fill_level: got %0d expected %0d", if_s.level, i + 1); end
            if (if_s.awfull !== ((i + 1) >= 12)) begin failures++; $display("FAIL fill_awfull: got %b at level %0d", if_s.awfull, i + 1); end
            if (if_s.wfull !== ((i + 1) == DEPTH)) begin failures++; $display("FAIL fill_wfull: got %b at level %0d", if_s.wfull, i + 1); end
        end
        for (int i = 0; i < DEPTH; i++) begin
            step_std(1'b0, 8'h00, 1'b1, 1'b0, ok, e);
            checks += 2;
            if (ok !== 1'b1 || e !== 8'(i)) begin failures++; $display("FAIL drain_model: got %h expected %h", e, 8'(i)); end
            if (if_s.rdata !== e) begin failures++; $display("FAIL drain_rdata: got %h expected %h", if_s.rdata, e); end
        end
        checks += 2;
        if (if_s.rempty !== 1'b1) begin failures++; $display("FAIL drain_rempty: got %b expected 1", if_s.rempty); end
        if (if_s.level !== 5'd0) begin failures++; $display("FAIL drain_level: got %0d expected 0", if_s.level); end
    endtask

    task automatic test_simultaneous();
        logic ok; logic [7:0] e;
        for (int i = 0; i < 8; i++) step_std(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, ok, e);
        for (int i = 0; i < 100; i++) begin
            step_std(1'b1, 8'($urandom), 1'b1, 1'b0, ok, e);
            checks += 2;
            if (if_s.level !== 5'd8) begin failures++; $display("FAIL simul_level: got %0d expected 8", if_s.level); end
            if (if_s.rdata !== e) begin failures++; $display("FAIL simul_rdata: got %h expected %h", if_s.rdata, e); end
        end
        for (int i = 0; i < 8; i++) step_std(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, ok, e);
        checks += 1;
        if (if_s.wfull !== 1'b1) begin failures++; $display("FAIL simul_full: got %b expected 1", if_s.wfull); end
        step_std(1'b1, 8'hEE, 1'b1, 1'b0, ok, e);
        checks += 4;
        if (if_s.level !== 5'd15) begin failures++; $display("FAIL full_rw_level: got %0d expected 15", if_s.level); end
        if (if_s.overflow !== ovf_m) begin failures++; $display("FAIL full_rw_overflow: got %b expected %b", if_s.overflow, ovf_m); end
        if (if_s.rdata !== e) begin failures++; $display("FAIL full_rw_rdata: got %h expected %h", if_s.rdata, e); end
        if (if_s.wfull !== 1'b0) begin failures++; $display("FAIL full_rw_wfull: got %b expected 0", if_s.wfull); end
        while (sb.size() > 0) begin
            step_std(1'b0, 8'h00, 1'b1, 1'b0, ok, e);
            checks += 1;
            if (if_s.rdata !== e) begin failures++; $display("FAIL full_drain_rdata: got %h expected %h", if_s.rdata, e); end
        end
        step_std(1'b0, 8'h00, 1'b0, 1'b1, ok, e);
        checks += 1;
        if (if_s.overflow !== 1'b0) begin failures++; $display("FAIL overflow_clr: got %b expected 0", if_s.overflow); end
    endtask

    task automatic test_thresholds();
        logic ok; logic [7:0] e;
        if_s.afull_th = 5'd0; #1;
        checks += 1;
        if (if_s.awfull !== 1'b1) begin failures++; $display("FAIL th_afull0: got %b expected 1", if_s.awfull); end
        if_s.afull_th = 5'd1; #1;
        checks += 1;
        if (if_s.awfull !== 1'b0) begin failures++; $display("FAIL th_afull1: got %b expected 0", if_s.awfull); end
        for (int i = 0; i < 3; i++) step_std(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, ok, e);
        if_s.aempty_th = 5'd2; #1;
        checks += 1;
        if (if_s.arempty !== 1'b0) begin failures++; $display("FAIL th_aempty2: got %b expected 0", if_s.arempty); end
        if_s.aempty_th = 5'd16; #1;
        checks += 1;
        if (if_s.arempty !== 1'b1) begin failures++; $display("FAIL th_aempty16: got %b expected 1", if_s.arempty); end
        if_s.aempty_th = 5'd3; #1;
        checks += 1;
        if (if_s.arempty !== 1'b1) begin failures++; $display("FAIL th_aempty3: got %b expected 1", if_s.arempty); end
        if_s.afull_th = 5'd3; #1;
        checks += 1;
        if (if_s.awfull !== 1'b1) begin failures++; $display("FAIL th_afull3: got %b expected 1", if_s.awfull); end
        if_s.afull_th = 5'd4; #1;
        checks += 1;
        if (if_s.awfull !== 1'b0) begin failures++; $display("FAIL th_afull4: got %b expected 0", if_s.awfull); end
        if_s.afull_th = 5'd12; if_s.aempty_th = 5'd2;
        while (sb.size() > 0) begin
            step_std(1'b0, 8'h00, 1'b1, 1'b0, ok, e);
            checks += 1;
            if (if_s.rdata !== e) begin failures++; $display("FAIL th_drain_rdata: got %h expected %h", if_s.rdata, e); end
        end
    endtask

    task automatic test_fwft();
        logic [7:0] fq[$];
        logic [7:0] wvals[3];
        wvals[0] = 8'hB1; wvals[1] = 8'hC2; wvals[2] = 8'hD3;
        if_f.winc = 1'b1; if_f.wdata = 8'hA5; fq.push_back(8'hA5);
        @(posedge clk); #1;
        if_f.winc = 1'b0;
        checks += 3;
        if (if_f.rempty !== 1'b0) begin failures++; $display("FAIL fwft_rempty: got %b expected 0", if_f.rempty); end
        if (if_f.rdata !== fq[0]) begin failures++; $display("FAIL fwft_head: got %h expected %h", if_f.rdata, fq[0]); end
        if (if_f.level !== 5'd1) begin failures++; $display("FAIL fwft_level: got %0d expected 1", if_f.level); end
        if_f.rinc = 1'b1; void'(fq.pop_front());
        @(posedge clk); #1;
        if_f.rinc = 1'b0;
        checks += 1;
        if (if_f.rempty !== 1'b1) begin failures++; $display("FAIL fwft_pop_rempty: got %b expected 1", if_f.rempty); end
        for (int i = 0; i < 2; i++) begin
            if_f.winc = 1'b1; if_f.wdata = wvals[i]; fq.push_back(wvals[i]);
            @(posedge clk); #1;
        end
        if_f.winc = 1'b0;
        checks += 1;
        if (if_f.rdata !== fq[0]) begin failures++; $display("FAIL fwft_head2: got %h expected %h", if_f.rdata, fq[0]); end
        if_f.rinc = 1'b1; void'(fq.pop_front());
        @(posedge clk); #1;
        checks += 1;
        if (if_f.rdata !== fq[0]) begin failures++; $display("FAIL fwft_head3: got %h expected %h", if_f.rdata, fq[0]); end
        if_f.winc = 1'b1; if_f.wdata = wvals[2];
        void'(fq.pop_front()); fq.push_back(wvals[2]);
        @(posedge clk); #1;
        if_f.winc = 1'b0;
        checks += 2;
        if (if_f.rdata !== fq[0]) begin failures++; $display("FAIL fwft_rw_head: got %h expected %h", if_f.rdata, fq[0]); end
        if (if_f.level !== 5'd1) begin failures++; $display("FAIL fwft_rw_level: got %0d expected 1", if_f.level); end
        void'(fq.pop_front());
        @(posedge clk); #1;
        if_f.rinc = 1'b0;
        checks += 1;
        if (if_f.rempty !== 1'b1) begin failures++; $display("FAIL fwft_final_rempty: got %b expected 1", if_f.rempty); end
    endtask

    task automatic test_errors();
        logic ok; logic [7:0] e;
        step_std(1'b0, 8'h00, 1'b1, 1'b0, ok, e);
        checks += 2;
        if (if_s.underflow !== 1'b1) begin failures++; $display("FAIL unf_set: got %b expected 1", if_s.underflow); end
        if (if_s.rdata !== exp_rdata) begin failures++; $display("FAIL unf_rdata_hold: got %h expected %h", if_s.rdata, exp_rdata); end
        step_std(1'b0, 8'h00, 1'b0, 1'b1, ok, e);
        checks += 1;
        if (if_s.underflow !== 1'b0) begin failures++; $display("FAIL unf_clr: got %b expected 0", if_s.underflow); end
        step_std(1'b0, 8'h00, 1'b1, 1'b1, ok, e);
        checks += 2;
        if (if_s.underflow !== 1'b1) begin failures++; $display("FAIL unf_set_wins: got %b expected 1", if_s.underflow); end
        if (if_s.overflow !== 1'b0) begin failures++; $display("FAIL unf_ovf_quiet: got %b expected 0", if_s.overflow); end
        step_std(1'b0, 8'h00, 1'b0, 1'b1, ok, e);
    endtask

    task automatic test_random_wrap();
        logic ok; logic [7:0] e; logic w; logic r;
        for (int i = 0; i < 1000; i++) begin
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 50);
            step_std(w, 8'($urandom), r, 1'b0, ok, e);
            checks += 6;
            if (if_s.level !== 5'(sb.size())) begin failures++; $display("FAIL rnd_level: got %0d expected %0d", if_s.level, sb.size()); end
            if (if_s.rdata !== exp_rdata) begin failures++; $display("FAIL rnd_rdata: got %h expected %h", if_s.rdata, exp_rdata); end
            if (if_s.wfull !== (sb.size() == DEPTH)) begin failures++; $display("FAIL rnd_wfull: got %b at level %0d", if_s.wfull, sb.size()); end
            if (if_s.rempty !== (sb.size() == 0)) begin failures++; $display("FAIL rnd_rempty: got %b at level %0d", if_s.rempty, sb.size()); end
            if (if_s.overflow !== ovf_m) begin failures++; $display("FAIL rnd_overflow: got %b expected %b", if_s.overflow, ovf_m); end
            if (if_s.underflow !== unf_m) begin failures++; $display("FAIL rnd_underflow: got %b expected %b", if_s.underflow, unf_m); end
        end
    endtask

    task automatic test_mid_reset();
        logic ok; logic [7:0] e;
        step_std(1'b0, 8'h00, 1'b0, 1'b1, ok, e);
        while (sb.size() < 5) step_std(1'b1, 8'(8'h50 + sb.size()), 1'b0, 1'b0, ok, e);
        if_s.winc = 1'b1; if_s.wdata = 8'h99;
        rst = 1'b1;
        #1;
        checks += 3;
        if (if_s.level !== 5'd0) begin failures++; $display("FAIL midrst_level: got %0d expected 0", if_s.level); end
        if (if_s.rempty !== 1'b1) begin failures++; $display("FAIL midrst_rempty: got %b expected 1", if_s.rempty); end
        if (if_s.rdata !== 8'h00) begin failures++; $display("FAIL midrst_rdata: got %h expected 00", if_s.rdata); end
        sb.delete(); exp_rdata = '0; ovf_m = 1'b0; unf_m = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; if_s.winc = 1'b0;
        step_std(1'b0, 8'h00, 1'b1, 1'b0, ok, e);
        checks += 2;
        if (if_s.rdata !== exp_rdata) begin failures++; $display("FAIL midrst_stale: got %h expected %h", if_s.rdata, exp_rdata); end
        if (if_s.rempty !== 1'b1) begin failures++; $display("FAIL midrst_empty_read: got %b expected 1", if_s.rempty); end
        step_std(1'b1, 8'h3C, 1'b0, 1'b0, ok, e);
        step_std(1'b0, 8'h00, 1'b1, 1'b0, ok, e);
        checks += 2;
        if (if_s.rdata !== e || e !== 8'h3C) begin failures++; $display("FAIL midrst_fresh: got %h expected 3c", if_s.rdata); end
        if (if_s.level !== 5'd0) begin failures++; $display("FAIL midrst_final_level: got %0d expected 0", if_s.level); end
    endtask

    initial begin
        rst = 1'b0;
        if_s.winc = 1'b0; if_s.wdata = '0; if_s.rinc = 1'b0; if_s.clr_err = 1'b0;
        if_s.afull_th = 5'd12; if_s.aempty_th = 5'd2;
        if_f.winc = 1'b0; if_f.wdata = '0; if_f.rinc = 1'b0; if_f.clr_err = 1'b0;
        if_f.afull_th = 5'd12; if_f.aempty_th = 5'd2;
        exp_rdata = '0; ovf_m = 1'b0; unf_m = 1'b0;
        test_reset();
        test_fill_drain();
        test_simultaneous();
        test_thresholds();
        test_fwft();
        test_errors();
        test_random_wrap();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO for datapaths that do not cross clock domains. It keeps the write/read flag interface of the team's dual-clock FIFO and adds:

- an exact fill level;
- runtime-programmable almost-full and almost-empty thresholds;
- a first-word-fall-through (FWFT) read mode;
- sticky overflow and underflow error flags.

## Interface
- DSIZE, 8: data width in bits.
- ASIZE, 4: address width; depth = 2**ASIZE entries.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- winc  in  1  write request.
- wdata  in  DSIZE  write data.
- wfull  out  1  FIFO full.
- awfull  out  1  almost full: level >= afull_th.
- rinc  in  1  read request.
- rdata  out  DSIZE  read data.
- rempty  out  1  FIFO empty.
- arempty  out  1  almost empty: level <= aempty_th.
- afull_th  in  ASIZE+1  almost-full threshold, sampled every cycle.
- aempty_th  in  ASIZE+1  almost-empty threshold, sampled every cycle.
- level  out  ASIZE+1  number of stored entries, 0..2**ASIZE.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- clr_err  in  1  synchronous clear of overflow and underflow.

## Operation
- **Pointers:** wptr and rptr are ASIZE+1-bit binary counters. The low ASIZE bits address the storage. Increments wrap modulo 2**(ASIZE+1).
- **Write acceptance:** a write is accepted when winc && !wfull. It stores wdata at wptr and increments wptr.
- **Write on full:** wfull blocks the write even if a read is accepted in the same cycle. No write-through on full.
- **Read acceptance:** a read is accepted when rinc && !rempty and increments rptr. A read is blocked on empty even if a write is accepted in the same cycle. No read-through on empty.
- **Level update:**
  - write only: level +1;
  - read only: level −1;
  - both: level unchanged;
  - neither: level unchanged.
  - level never leaves 0..2**ASIZE.
- **Flag derivation:**
  - wfull = (level == 2**ASIZE);
  - rempty = (level == 0);
  - awfull and arempty are combinational compares of the registered level against the live threshold ports.
- **Standard mode (FWFT=0):**
  - rdata is a register, loaded with mem[rptr] on each accepted read.
  - Otherwise rdata holds its value.
- **FWFT mode (FWFT=1):**
  - rdata = mem[rptr] combinationally whenever rempty = 0. The head word is presented before rinc.
  - rinc pops the head word.
  - rdata is don't-care while rempty = 1.
- **Error flags:**
  - overflow sets on winc && wfull; underflow sets on rinc && rempty.
  - clr_err clears both flags.
  - If a set and clr_err occur in the same cycle, the set wins.
- **Threshold edge cases:** afull_th = 0 forces awfull = 1. aempty_th >= 2**ASIZE forces arempty = 1.

## Timing
- **Reset values** (on rst assertion, asynchronously):
  - level = 0, wptr = 0, rptr = 0;
  - rempty = 1, wfull = 0, arempty = 1;
  - awfull = (afull_th == 0);
  - overflow = 0, underflow = 0;
  - rdata = 0.
- **Storage is not reset.** Reset in mid-operation discards all contents immediately.
- **Write to not-empty:** a write accepted at edge N gives level = 1 and rempty = 0 after edge N.
- **FWFT read data:** rdata is valid in the same cycle rempty falls.
- **Standard read latency:** a read accepted at edge N presents its data on rdata after edge N, i.e. one cycle of read latency.
- **Full-to-not-full:** a read accepted at edge N deasserts wfull after edge N. A write is then possible at edge N+1.
- **Throughput:** sustained one write and one read per cycle at any level, except that a full FIFO cannot accept a write and an empty FIFO cannot satisfy a read.
- **Threshold response:** awfull and arempty respond within the same cycle to threshold port changes. There is no pipeline on these outputs.

## Structure
- **Shared package sync_fifo_pkg:**
  - mode constants FIFO_STD = 0 and FIFO_FWFT = 1;
  - a depth function returning 2**ASIZE.
- **Sub-module sync_fifo_ram:**
  - a flop array of 2**ASIZE × DSIZE;
  - write port gated by the accepted-write strobe;
  - asynchronous read port addressed by rptr[ASIZE-1:0].
- **Top level** holds the pointers, level counter, flags, error logic and the FWFT/standard output selection.

## Test plan
1. **Reset:** assert rst with afull_th = 12 and aempty_th = 2 → level = 0, rempty = 1, arempty = 1, wfull = 0, awfull = 0, rdata = 0.
2. **Fill and drain (ASIZE = 4, FWFT = 0):**
   - write 0x00..0x0F → wfull = 1 after the 16th write and level = 16; awfull rises when level reaches 12.
   - read 16 → rdata = 0x00..0x0F in order, each one cycle after its rinc; rempty = 1 at the end.
3. **Simultaneous read and write:** at level = 8, winc = rinc = 1 for 100 cycles → level stays 8 and data order is preserved. At level = 16 with winc = rinc = 1 → the read is accepted, the write is rejected, overflow = 1, and level becomes 15.
4. **FWFT = 1:** write 0xA5 into an empty FIFO → the next cycle shows rempty = 0 and rdata = 0xA5 before any rinc. rinc → rempty = 1.
5. **Error flags:** rinc while empty → underflow = 1. clr_err → underflow = 0. clr_err together with a rinc on empty → underflow stays 1.
6. **Pointer wrap and mid-traffic reset:** run 1000 random cycles and compare against a reference model, including more than 3 pointer wraps. Then assert rst mid-burst → level = 0 and rempty = 1 immediately, with no stale data on the next reads.
